// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage: default widths, reset PC,
// sequential PC step and the canonical NOP encoding.
package fetch_unit_pkg;

  localparam int          DEFAULT_ADDRESS_BITS = 16;
  localparam int          DEFAULT_RESET_PC     = 0;
  localparam int          PC_INCREMENT         = 4;
  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int ADDRESS_BITS = DEFAULT_ADDRESS_BITS
);

  logic                    imem_req;
  logic [ADDRESS_BITS-1:0] imem_addr;
  logic                    imem_gnt;
  logic                    imem_rvalid;
  logic [31:0]             imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count and a synchronous flush.
// Head is read combinationally from storage; contents are meaningless when empty.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_BITS   = $clog2(DEPTH),
  localparam int COUNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [COUNT_BITS-1:0] count,
  output logic                  full,
  output logic                  empty
);

  logic [WIDTH-1:0]    storage [DEPTH];
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS-1:0] wr_ptr;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == COUNT_BITS'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = storage[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) storage[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential requests to a variable-latency
// instruction memory, buffers in-order responses and discards stale ones after a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                      ADDRESS_BITS = DEFAULT_ADDRESS_BITS,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = ADDRESS_BITS'(DEFAULT_RESET_PC),
  parameter int                      DEPTH        = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  fetch_unit_if.master            imem,
  input  logic                    next_PC_select,
  input  logic [ADDRESS_BITS-1:0] target_PC,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [ADDRESS_BITS-1:0] PC,
  output logic [31:0]             instr
);

  localparam int                      COUNT_BITS = $clog2(DEPTH + 1);
  localparam int                      ENTRY_BITS = ADDRESS_BITS + 32;
  localparam logic [COUNT_BITS:0]     SLOT_LIMIT = (COUNT_BITS + 1)'(DEPTH);
  localparam logic [ADDRESS_BITS-1:0] PC_STEP    = ADDRESS_BITS'(PC_INCREMENT);

  logic [ADDRESS_BITS-1:0] fetch_pc;
  logic [COUNT_BITS-1:0]   drop_count;
  logic [ADDRESS_BITS-1:0] shown_pc;
  logic [31:0]             shown_instr;

  logic [ADDRESS_BITS-1:0] pend_head;
  logic [COUNT_BITS-1:0]   pend_count;
  logic                    pend_full;
  logic                    pend_empty;
  logic [ENTRY_BITS-1:0]   buf_head;
  logic [COUNT_BITS-1:0]   buf_count;
  logic                    buf_full;
  logic                    buf_empty;

  logic                    grant;
  logic                    response;
  logic                    dropping;
  logic                    consume;
  logic                    buf_push;
  logic [COUNT_BITS:0]     slots_after_consume;
  logic                    unused_flags;

  assign response = imem.imem_rvalid;
  assign dropping = (drop_count != '0);
  assign consume  = instr_valid && instr_ready && !next_PC_select;
  assign buf_push = response && !dropping && !next_PC_select;
  assign grant    = imem.imem_req && imem.imem_gnt;

  // A consume in the same cycle frees a slot, which keeps one-per-cycle streaming.
  assign slots_after_consume = (COUNT_BITS + 1)'(pend_count) + (COUNT_BITS + 1)'(buf_count)
                             - (COUNT_BITS + 1)'(consume);

  assign imem.imem_req  = !reset && !next_PC_select && (slots_after_consume < SLOT_LIMIT);
  assign imem.imem_addr = fetch_pc;

  assign instr_valid = !buf_empty;
  assign PC          = buf_empty ? shown_pc    : buf_head[ENTRY_BITS-1:32];
  assign instr       = buf_empty ? shown_instr : buf_head[31:0];

  assign unused_flags = ^{pend_full, pend_empty, buf_full};

  fetch_fifo #(
    .WIDTH (ADDRESS_BITS),
    .DEPTH (DEPTH)
  ) pending_pc_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (1'b0),
    .push      (grant),
    .push_data (fetch_pc),
    .pop       (response),
    .head      (pend_head),
    .count     (pend_count),
    .full      (pend_full),
    .empty     (pend_empty)
  );

  fetch_fifo #(
    .WIDTH (ENTRY_BITS),
    .DEPTH (DEPTH)
  ) instr_buffer (
    .clock     (clock),
    .reset     (reset),
    .flush     (next_PC_select),
    .push      (buf_push),
    .push_data ({pend_head, imem.imem_rdata}),
    .pop       (consume),
    .head      (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // Every request still in flight after a redirect cycle is stale, including
  // ones already marked for dropping, so the new drop count is simply that total.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      drop_count <= '0;
    end else if (next_PC_select) begin
      fetch_pc   <= target_PC;
      drop_count <= pend_count - COUNT_BITS'(response);
    end else begin
      if (grant)                fetch_pc   <= fetch_pc + PC_STEP;
      if (response && dropping) drop_count <= drop_count - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shown_pc    <= '0;
      shown_instr <= '0;
    end else if (!buf_empty) begin
      shown_pc    <= buf_head[ENTRY_BITS-1:32];
      shown_instr <= buf_head[31:0];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, PC wrap
// and asynchronous reset, against an in-order one-cycle-latency memory model.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        next_PC_select;
  logic [15:0] target_PC;
  logic        instr_ready;
  logic        instr_valid;
  logic [15:0] PC;
  logic [31:0] instr;
  logic        wrap_valid;
  logic [15:0] wrap_pc;
  logic [31:0] wrap_instr;

  logic        obs_req;
  logic [15:0] obs_addr;
  logic        obs_valid;
  logic [15:0] obs_pc;
  logic [31:0] obs_instr;
  logic [15:0] wrap_obs_addr;
  logic        wrap_obs_valid;
  logic [15:0] wrap_obs_pc;
  logic [31:0] wrap_obs_instr;

  logic [15:0] mem_q [$];
  logic [15:0] wrap_q [$];

  int pass_checks  = 0;
  int total_checks = 0;

  always #5 clock = ~clock;

  fetch_unit_if #(.ADDRESS_BITS(16)) imem_bus ();
  fetch_unit_if #(.ADDRESS_BITS(16)) wrap_bus ();

  fetch_unit #(
    .ADDRESS_BITS (16),
    .RESET_PC     (16'h0000),
    .DEPTH        (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem           (imem_bus),
    .next_PC_select (next_PC_select),
    .target_PC      (target_PC),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .PC             (PC),
    .instr          (instr)
  );

  fetch_unit #(
    .ADDRESS_BITS (16),
    .RESET_PC     (16'hFFFC),
    .DEPTH        (2)
  ) wrap_dut (
    .clock          (clock),
    .reset          (reset),
    .imem           (wrap_bus),
    .next_PC_select (1'b0),
    .target_PC      (16'h0000),
    .instr_valid    (wrap_valid),
    .instr_ready    (1'b1),
    .PC             (wrap_pc),
    .instr          (wrap_instr)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total_checks++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    else
      pass_checks++;
  endtask

  // Drives one cycle of inputs and memory responses, samples outputs mid-cycle,
  // then records grants so the memory model answers them in order next cycle.
  task automatic applyStimulus(input logic sel, input logic [15:0] tgt, input logic ready, input logic resp_en);
    next_PC_select   = sel;
    target_PC        = tgt;
    instr_ready      = ready;
    imem_bus.imem_gnt = 1'b1;
    wrap_bus.imem_gnt = 1'b1;
    if (resp_en && mem_q.size() > 0) begin
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = 32'h0000_1000 + 32'(mem_q[0]);
    end else begin
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = '0;
    end
    if (wrap_q.size() > 0) begin
      wrap_bus.imem_rvalid = 1'b1;
      wrap_bus.imem_rdata  = 32'h0000_1000 + 32'(wrap_q[0]);
    end else begin
      wrap_bus.imem_rvalid = 1'b0;
      wrap_bus.imem_rdata  = '0;
    end
    #1;
    obs_req        = imem_bus.imem_req;
    obs_addr       = imem_bus.imem_addr;
    obs_valid      = instr_valid;
    obs_pc         = PC;
    obs_instr      = instr;
    wrap_obs_addr  = wrap_bus.imem_addr;
    wrap_obs_valid = wrap_valid;
    wrap_obs_pc    = wrap_pc;
    wrap_obs_instr = wrap_instr;
    if (imem_bus.imem_rvalid) void'(mem_q.pop_front());
    if (imem_bus.imem_req && imem_bus.imem_gnt) mem_q.push_back(imem_bus.imem_addr);
    if (wrap_bus.imem_rvalid) void'(wrap_q.pop_front());
    if (wrap_bus.imem_req && wrap_bus.imem_gnt) wrap_q.push_back(wrap_bus.imem_addr);
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset                = 1'b1;
    next_PC_select       = 1'b0;
    target_PC            = '0;
    instr_ready          = 1'b0;
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;
    wrap_bus.imem_gnt    = 1'b0;
    wrap_bus.imem_rvalid = 1'b0;
    wrap_bus.imem_rdata  = '0;
    mem_q.delete();
    wrap_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    next_PC_select       = 1'b0;
    target_PC            = '0;
    instr_ready          = 1'b0;
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;
    wrap_bus.imem_gnt    = 1'b0;
    wrap_bus.imem_rvalid = 1'b0;
    wrap_bus.imem_rdata  = '0;
    #1 reset = 1'b1;
    #1;
    checkOutput("reset_valid", 64'(instr_valid), 64'(0));
    checkOutput("reset_req",   64'(imem_bus.imem_req), 64'(0));
    checkOutput("reset_pc",    64'(PC), 64'(0));
    checkOutput("reset_instr", 64'(instr), 64'(0));

    // Streaming: one request and, after two cycles of latency, one instruction per cycle.
    doReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
      checkOutput("stream_req",  64'(obs_req), 64'(1));
      checkOutput("stream_addr", 64'(obs_addr), 64'(4 * k));
      if (k < 2) begin
        checkOutput("stream_valid_early", 64'(obs_valid), 64'(0));
      end else begin
        checkOutput("stream_valid", 64'(obs_valid), 64'(1));
        checkOutput("stream_pc",    64'(obs_pc), 64'(4 * (k - 2)));
        checkOutput("stream_instr", 64'(obs_instr), 64'(32'h1000 + 4 * (k - 2)));
      end
      if (k == 0) checkOutput("wrap_addr0", 64'(wrap_obs_addr), 64'(16'hFFFC));
      if (k == 1) checkOutput("wrap_addr1", 64'(wrap_obs_addr), 64'(16'h0000));
      if (k == 2) begin
        checkOutput("wrap_addr2",  64'(wrap_obs_addr), 64'(16'h0004));
        checkOutput("wrap_valid",  64'(wrap_obs_valid), 64'(1));
        checkOutput("wrap_pc",     64'(wrap_obs_pc), 64'(16'hFFFC));
        checkOutput("wrap_instr",  64'(wrap_obs_instr), 64'(32'h0001_0FFC));
      end
    end

    // Backpressure: two grants fill the slots, then release delivers 0, 4, 8 in order.
    doReset();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("bp_addr0", 64'(obs_addr), 64'(16'h0000));
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("bp_addr1", 64'(obs_addr), 64'(16'h0004));
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("bp_full_req", 64'(obs_req), 64'(0));
    checkOutput("bp_pc_hold0", 64'(obs_pc), 64'(16'h0000));
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("bp_still_full", 64'(obs_req), 64'(0));
    checkOutput("bp_instr0",     64'(obs_instr), 64'(32'h1000));
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("bp_rel_pc0",   64'(obs_pc), 64'(16'h0000));
    checkOutput("bp_resume_req",  64'(obs_req), 64'(1));
    checkOutput("bp_resume_addr", 64'(obs_addr), 64'(16'h0008));
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("bp_rel_pc4",    64'(obs_pc), 64'(16'h0004));
    checkOutput("bp_rel_instr4", 64'(obs_instr), 64'(32'h1004));
    checkOutput("bp_addr_c",     64'(obs_addr), 64'(16'h000C));
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("bp_rel_pc8", 64'(obs_pc), 64'(16'h0008));
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("bp_refill_req", 64'(obs_req), 64'(0));
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("bp_refill_valid", 64'(obs_valid), 64'(1));
    checkOutput("bp_refill_pc",    64'(obs_pc), 64'(16'h000C));

    // Asynchronous reset with a full buffer clears outputs before any clock edge.
    #2 reset = 1'b1;
    #1;
    checkOutput("async_valid", 64'(instr_valid), 64'(0));
    checkOutput("async_req",   64'(imem_bus.imem_req), 64'(0));
    checkOutput("async_pc",    64'(PC), 64'(0));
    checkOutput("async_instr", 64'(instr), 64'(0));

    // Redirect with 8 and C outstanding; two back-to-back redirects, last one wins.
    doReset();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("post_reset_addr", 64'(obs_addr), 64'(16'h0000));
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("rd_addr_c", 64'(obs_addr), 64'(16'h000C));
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("rd_stall_req", 64'(obs_req), 64'(0));
    checkOutput("rd_pc_hold",   64'(obs_pc), 64'(16'h0004));
    applyStimulus(1'b1, 16'h0180, 1'b1, 1'b0);
    checkOutput("rd_req_forced0", 64'(obs_req), 64'(0));
    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0);
    checkOutput("rd_req_forced1", 64'(obs_req), 64'(0));
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("rd_drop8_valid", 64'(obs_valid), 64'(0));
    checkOutput("rd_drop8_req",   64'(obs_req), 64'(0));
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("rd_dropc_valid", 64'(obs_valid), 64'(0));
    checkOutput("rd_new_addr",    64'(obs_addr), 64'(16'h0100));
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("rd_no_bypass", 64'(obs_valid), 64'(0));
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("rd_first_valid", 64'(obs_valid), 64'(1));
    checkOutput("rd_first_pc",    64'(obs_pc), 64'(16'h0100));
    checkOutput("rd_first_instr", 64'(obs_instr), 64'(32'h1100));

    // Redirect coinciding with a response and a consume.
    doReset();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    applyStimulus(1'b1, 16'h0200, 1'b1, 1'b1);
    checkOutput("rc_req",       64'(obs_req), 64'(0));
    checkOutput("rc_shown_pc",  64'(obs_pc), 64'(16'h0004));
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("rc_flushed",   64'(obs_valid), 64'(0));
    checkOutput("rc_pc_hold",   64'(obs_pc), 64'(16'h0004));
    checkOutput("rc_new_addr",  64'(obs_addr), 64'(16'h0200));
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("rc_no_stale",  64'(obs_valid), 64'(0));
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("rc_valid",     64'(obs_valid), 64'(1));
    checkOutput("rc_pc",        64'(obs_pc), 64'(16'h0200));
    checkOutput("rc_instr",     64'(obs_instr), 64'(32'h1200));
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("rc_next_pc",   64'(obs_pc), 64'(16'h0204));

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; the upstream end of the decode interface.
- Produces the PC/instr pair that decode consumes and accepts decode's redirect (next_PC_select, target_PC).
- Issues requests to a variable-latency instruction memory, tracks outstanding requests, and buffers returned instructions.
- Discards stale responses after a redirect.

Parameters:
- ADDRESS_BITS, 16: width of PC, target_PC and imem_addr.
- RESET_PC, 0: PC fetched first after reset; ADDRESS_BITS wide.
- DEPTH, 2: maximum outstanding requests plus buffered instructions; power of two, at least 2.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- next_PC_select  in  1  redirect request from decode.
- target_PC  in  ADDRESS_BITS  redirect address, valid when next_PC_select=1.
- imem_req  out  1  request valid.
- imem_addr  out  ADDRESS_BITS  request address.
- imem_gnt  in  1  request accepted this cycle (only meaningful when imem_req=1).
- imem_rvalid  in  1  response valid; responses return in request order.
- imem_rdata  in  32  response instruction word.
- instr_valid  out  1  PC/instr presented to decode.
- instr_ready  in  1  decode consumes the presented pair.
- PC  out  ADDRESS_BITS  address of the presented instruction.
- instr  out  32  presented instruction.

Behaviour:
- Reset (asynchronous, immediate):
  - fetch_pc=RESET_PC.
  - Outstanding count=0, drop count=0, buffers empty.
  - imem_req=0, instr_valid=0, PC=0, instr=0.
  - First request is issued in the first cycle after reset deasserts.
- Memory assumptions:
  - Each granted request returns exactly one response, at least 1 cycle after its grant.
  - imem_rvalid is never asserted without a prior grant.
- Request issue: imem_req=1 when (outstanding + buffered) < DEPTH and next_PC_select=0. imem_addr=fetch_pc.
- Grant (imem_req&imem_gnt):
  - Push fetch_pc into the pending-PC queue.
  - fetch_pc <= fetch_pc+4, modulo 2^ADDRESS_BITS (0xFFFC -> 0x0000 at ADDRESS_BITS=16).
  - Outstanding +1.
- Response (imem_rvalid):
  - Pop the pending-PC queue; outstanding -1.
  - If drop count>0: discard and decrement drop count.
  - Otherwise push {pc, imem_rdata} into the instruction buffer.
- Output:
  - instr_valid = buffer not empty; PC/instr = buffer head; head is combinational from buffer storage.
  - When the buffer is empty, PC/instr hold their last value.
  - Pop on instr_valid&instr_ready.
  - A response can be presented no earlier than the cycle after it arrives; no rvalid->instr_valid bypass.
- Redirect (next_PC_select=1), takes priority over everything else:
  - imem_req forced 0.
  - A consume in that cycle is ignored (no pop).
  - fetch_pc <= target_PC; instruction buffer flushed.
  - drop count <= current outstanding minus (1 if imem_rvalid this cycle), plus the existing drop count already folded in. A response arriving in the redirect cycle is discarded.
  - Pending-PC queue is left intact so stale responses still pop correctly.
  - instr_valid=0 from the next cycle until a post-redirect response arrives.
- Back-to-back redirects: the last target wins; drop accounting stays correct.
- Simultaneous grant, response and consume in one cycle: all three take effect; counts stay consistent.
- Full: with DEPTH entries in use, imem_req=0; no instruction is ever lost under backpressure.
- Throughput: with imem_gnt=1, 1-cycle response latency and instr_ready=1, one instruction per cycle in steady state.

Decomposition:
- Shared package: ADDRESS_BITS default, RESET_PC default, PC increment constant (4), NOP encoding 32'h00000013.
- Natural sub-module: fetch_fifo, a parameterised synchronous FIFO (width, depth) with count, full and empty outputs.
  - Instantiated twice: pending-PC queue (ADDRESS_BITS wide) and instruction buffer (ADDRESS_BITS+32 wide).
  - Flush input used on the instruction buffer only.

Test Plan:
- Streaming, DEPTH=2, RESET_PC=0, gnt=1, rvalid 1 cycle after grant, rdata=0x1000+addr, instr_ready=1 -> imem_addr 0,4,8,... on consecutive cycles; first instr_valid 2 cycles after reset release with PC=0, instr=0x1000; thereafter one per cycle, in order.
- Backpressure: instr_ready=0 from start -> imem_req drops after 2 grants; buffer holds PC 0 and 4; instr_ready=1 -> PC 0 then 4 delivered, then requests resume at 8; nothing lost or duplicated.
- Redirect with 2 outstanding (addr 8 and C granted, responses pending), next_PC_select=1, target_PC=0x0100 -> responses for 8 and C are discarded; next imem_addr=0x0100; first post-redirect instr_valid shows PC=0x0100.
- Redirect in the same cycle as rvalid and a consume -> that response is dropped, buffer is flushed, no pop occurs, drop count is correct, and no stale PC is ever presented.
- Wrap: RESET_PC=0xFFFC, ADDRESS_BITS=16 -> imem_addr sequence 0xFFFC, 0x0000, 0x0004.
- Reset asserted mid-flight with a full buffer -> instr_valid, imem_req, PC and instr go 0 immediately, before the next clock; after deassertion, first imem_addr=RESET_PC.
